ci_divider: RTL and testbench
=============================

CI_DIVIDER -- requirements
Module: ci_divider

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width in bits (legal 8..32).
REQ-002 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port rst_n  input  1  asynchronous, active-high reset (asserted = 1 despite the name).
REQ-004 SHALL provide port clk_en  input  1  clock enable; state advances only when 1.
REQ-005 SHALL provide port start  input  1  operation request, sampled on edges where clk_en=1.
REQ-006 SHALL provide port n  input  2  mode: n[0]=0 quotient, n[0]=1 remainder; n[1]=1 signed (see Configuration).
REQ-007 SHALL provide port dataa  input  WIDTH  dividend.
REQ-008 SHALL provide port datab  input  WIDTH  divisor.
REQ-009 SHALL provide port result  output  WIDTH  selected quotient or remainder, registered.
REQ-010 SHALL provide port done  output  1  one-cycle completion pulse.
REQ-011 SHALL provide port busy  output  1  high while an operation is in progress.
REQ-012 SHALL provide port div_zero  output  1  registered flag, high with done when datab was 0.

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> FIN -> IDLE; all transitions gated by clk_en.
REQ-014 IDLE: on start=1 SHALL latch dataa, datab, n; go to CALC, or to FIN directly if datab=0.
REQ-015 CALC SHALL run restoring division, one quotient bit per enabled cycle, MSB first, using a WIDTH+1-bit partial remainder.
REQ-016 CALC SHALL last exactly WIDTH enabled cycles (internal bit counter) then go to FIN.
REQ-017 FIN SHALL load result (quotient or remainder per latched n[0]), assert done for exactly one cycle, return to IDLE.
REQ-018 Latency SHALL be WIDTH+2 enabled edges from the start edge to the edge that raises done; divide-by-zero: 2 edges.
REQ-019 Divide-by-zero SHALL give quotient all-ones, remainder = dividend, div_zero=1.
REQ-020 busy SHALL be 1 in CALC and FIN, 0 in IDLE.
REQ-021 start while busy=1 SHALL be ignored; no queuing.
REQ-022 clk_en=0 SHALL freeze all state and outputs; done SHALL NOT be asserted while clk_en=0 and SHALL resume on re-enable.
REQ-023 result and div_zero SHALL hold their value until the next FIN or reset.
REQ-024 start in the same enabled cycle that done is high SHALL be accepted (back-to-back operation).

Reset
REQ-025 rst_n=1 SHALL asynchronously force IDLE, counter 0, result 0, done 0, busy 0, div_zero 0.
REQ-026 Reset mid-operation SHALL abort with no done pulse; the first start after reset release SHALL be accepted normally.

Configuration
REQ-027 Macro CI_DIVIDER_SIGNED_EN SHALL compile in signed support.
REQ-028 With the macro, n[1]=1 SHALL divide the operand magnitudes, negate the quotient when signs differ, and give the remainder the dividend's sign.
REQ-029 With the macro, most-negative / -1 SHALL return quotient = most-negative (wrap) and remainder 0.
REQ-030 With the macro, signed divide-by-zero SHALL give quotient all-ones and remainder = dividend, unchanged.
REQ-031 Without the macro, n[1] SHALL be ignored, all operations SHALL be unsigned, and no sign logic SHALL be synthesised.

Verification
REQ-032 WIDTH=32, dataa=100, datab=7, n=0, start: done after 34 enabled edges, result=14; repeat with n=1: result=2.
REQ-033 dataa=0x12345678, datab=0, n=0: done after 2 edges, result=0xFFFFFFFF, div_zero=1; with n=1: result=0x12345678.
REQ-034 Macro on, n=2'b11, dataa=-7, datab=2: result=0xFFFFFFFF (-1); n=2'b10: result=0xFFFFFFFD (-3); 0x80000000 / 0xFFFFFFFF, n=2'b10: result=0x80000000.
REQ-035 100/7 with clk_en held low 5 cycles mid-CALC: done 5 cycles later than in REQ-032, result=14; second start during busy: no effect.
REQ-036 Assert rst_n at edge 10 of an operation: result=0, busy=0, no done; next start 200/10: result=20.

Source files
------------

// File: rtl/ci_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : ci_divider_if
// Brief    : Request/response bundle for the ci_divider custom-instruction
//            divider: clock enable, start/mode/operands in, result/status out.
// Revision : 1.0 - initial release
// ============================================================================
interface ci_divider_if #(
  parameter int WIDTH = 32
);
  logic             clk_en;
  logic             start;
  logic [1:0]       n;
  logic [WIDTH-1:0] dataa;
  logic [WIDTH-1:0] datab;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             div_zero;

  // Requester side: drives the operation, observes the outcome.
  modport master (
    output clk_en, start, n, dataa, datab,
    input  result, done, busy, div_zero
  );

  // Divider side.
  modport slave (
    input  clk_en, start, n, dataa, datab,
    output result, done, busy, div_zero
  );
endinterface
`default_nettype wire

// File: rtl/ci_divider.sv
`default_nettype none
// ============================================================================
// Module   : ci_divider
// Brief    : Multi-cycle restoring divider (one quotient bit per enabled
//            cycle). Returns quotient or remainder, flags divide-by-zero.
//            Optional signed mode is compiled in with `CI_DIVIDER_SIGNED_EN;
//            without it n[1] is ignored and no sign logic exists.
// Revision : 1.0 - initial release
// ============================================================================
module ci_divider #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,   // active-high asynchronous reset
  ci_divider_if.slave  bus
);

  localparam int c_CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_quo;       // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]     r_div;       // divisor magnitude
  logic [WIDTH:0]       r_rem;       // partial remainder
  logic                 r_rem_sel;   // latched n[0]
  logic                 r_dz_pend;   // operation was a divide-by-zero
  logic [WIDTH-1:0]     r_result;
  logic                 r_done;
  logic                 r_busy;
  logic                 r_div_zero;

  logic                 w_b_zero;
  logic [WIDTH-1:0]     w_op_a;
  logic [WIDTH-1:0]     w_op_b;
  logic [WIDTH+1:0]     w_shift;
  logic [WIDTH+1:0]     w_diff;
  logic                 w_qbit;
  logic [WIDTH-1:0]     w_quo_fin;
  logic [WIDTH-1:0]     w_rem_fin;
  logic [WIDTH-1:0]     w_res_fin;

  assign w_b_zero = (bus.datab == '0);

`ifdef CI_DIVIDER_SIGNED_EN
  logic w_sgn_a;
  logic w_sgn_b;
  logic r_neg_q;
  logic r_neg_r;

  // Signed requests divide magnitudes; signs are restored at FIN.
  assign w_sgn_a   = bus.n[1] & bus.dataa[WIDTH-1];
  assign w_sgn_b   = bus.n[1] & bus.datab[WIDTH-1];
  assign w_op_a    = w_sgn_a ? -bus.dataa : bus.dataa;
  assign w_op_b    = w_sgn_b ? -bus.datab : bus.datab;
  assign w_quo_fin = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fin = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
`else
  logic w_unused_sign;

  // Unsigned only: the sign-mode bit has no effect.
  assign w_unused_sign = bus.n[1];
  assign w_op_a        = bus.dataa;
  assign w_op_b        = bus.datab;
  assign w_quo_fin     = r_quo;
  assign w_rem_fin     = r_rem[WIDTH-1:0];
`endif

  // One restoring step: shift in the next dividend bit and trial-subtract.
  // The extra top bit of w_diff is the borrow that rejects the subtraction.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {2'b00, r_div};
  assign w_qbit  = ~w_diff[WIDTH+1];

  // Divide-by-zero keeps the raw dividend in r_quo, so it doubles as the
  // remainder; the quotient is all-ones regardless of sign mode.
  assign w_res_fin = r_dz_pend ? (r_rem_sel ? r_quo : '1)
                               : (r_rem_sel ? w_rem_fin : w_quo_fin);

  // Control FSM and datapath; everything advances only on enabled edges.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_quo      <= '0;
      r_div      <= '0;
      r_rem      <= '0;
      r_rem_sel  <= 1'b0;
      r_dz_pend  <= 1'b0;
      r_result   <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_div_zero <= 1'b0;
`ifdef CI_DIVIDER_SIGNED_EN
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
`endif
    end else if (bus.clk_en) begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_quo     <= w_b_zero ? bus.dataa : w_op_a;
            r_div     <= w_op_b;
            r_rem     <= '0;
            r_rem_sel <= bus.n[0];
            r_dz_pend <= w_b_zero;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= w_b_zero ? S_FIN : S_CALC;
`ifdef CI_DIVIDER_SIGNED_EN
            r_neg_q   <= ~w_b_zero & (w_sgn_a ^ w_sgn_b);
            r_neg_r   <= ~w_b_zero & w_sgn_a;
`endif
          end
        end
        S_CALC: begin
          r_rem <= w_qbit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
          r_quo <= {r_quo[WIDTH-2:0], w_qbit};
          if (r_cnt == c_CNT_W'(WIDTH - 1)) begin
            r_cnt   <= '0;
            r_state <= S_FIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIN: begin
          r_result   <= w_res_fin;
          r_div_zero <= r_dz_pend;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // done is held in r_done while disabled and only shown when enabled, so a
  // completion that lands just before a stall appears once clk_en returns.
  assign bus.done     = r_done & bus.clk_en;
  assign bus.result   = r_result;
  assign bus.busy     = r_busy;
  assign bus.div_zero = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_ci_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_ci_divider
// Brief    : Directed bench for ci_divider (WIDTH=32) with a result
//            scoreboard; covers latency, divide-by-zero, clock-enable stalls,
//            ignored starts, reset abort and (when built) signed mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ci_divider;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  logic [32:0] sb_q[$];   // {div_zero, result}

  ci_divider_if #(.WIDTH(32)) bus ();

  ci_divider #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter used to measure latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: {div_zero, result}.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] nn);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    if (b == 32'd0) return {1'b1, (nn[0] ? a : 32'hFFFF_FFFF)};
`ifdef CI_DIVIDER_SIGNED_EN
    if (nn[1]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
      return {1'b0, (nn[0] ? r : q)};
    end
`endif
    q = a / b;
    r = a % b;
    return {1'b0, (nn[0] ? r : q)};
  endfunction

  // Scoreboard: every visible done pulse must match the oldest expectation.
  always @(negedge clk) begin
    logic [32:0] e;
    if (bus.done) begin
      checks++;
      assert (sb_q.size() > 0) else begin
        errors++;
        $error("FAIL done_unexpected observed=done expected=no_done");
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("result", bus.result, e[31:0]);
        check("div_zero", {31'd0, bus.div_zero}, {31'd0, e[32]});
      end
    end
  end

  // Wait (bounded) for done; report latency counted from the start edge as 1.
  task automatic wait_done(input int t0, input int exp_lat, input string tag);
    int lat;
    while (!bus.done && (cyc - t0) < 200) begin
      @(posedge clk);
      #1;
    end
    lat = cyc - t0 + 1;
    check(tag, lat, exp_lat);
    check("busy_at_done", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] nn, input int exp_lat);
    int t0;
    sb_q.push_back(model(a, b, nn));
    @(negedge clk);
    bus.dataa = a;
    bus.datab = b;
    bus.n     = nn;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.dataa = $urandom;   // operands must have been latched
    bus.datab = $urandom;
    bus.n     = 2'($urandom_range(0, 3));
    wait_done(t0, exp_lat, "latency");
  endtask

  initial begin
    int t0;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rn;

    cyc        = 0;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b1;
    bus.clk_en = 1'b1;
    bus.start  = 1'b0;
    bus.n      = 2'b00;
    bus.dataa  = '0;
    bus.datab  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_result", bus.result, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_div_zero", {31'd0, bus.div_zero}, 32'd0);
    rst_n = 1'b0;

    // Basic quotient / remainder, then divide-by-zero (back-to-back starts)
    run_op(32'd100, 32'd7, 2'b00, 34);
    run_op(32'd100, 32'd7, 2'b01, 34);
    repeat (3) @(negedge clk);
    check("hold_result", bus.result, 32'd2);
    check("hold_done", {31'd0, bus.done}, 32'd0);
    run_op(32'h1234_5678, 32'd0, 2'b00, 2);
    run_op(32'h1234_5678, 32'd0, 2'b01, 2);
    repeat (2) @(negedge clk);
    check("hold_div_zero", {31'd0, bus.div_zero}, 32'd1);
    run_op(32'hFFFF_FFFF, 32'd1, 2'b00, 34);
    run_op(32'd5, 32'd9, 2'b00, 34);
    run_op(32'd5, 32'd9, 2'b01, 34);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 34);

    // Sign mode
`ifdef CI_DIVIDER_SIGNED_EN
    run_op(32'hFFFF_FFF9, 32'd2, 2'b11, 34);
    run_op(32'hFFFF_FFF9, 32'd2, 2'b10, 34);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 34);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 34);
    run_op(32'd7, 32'hFFFF_FFFE, 2'b11, 34);
    run_op(32'hFFFF_FFFB, 32'd0, 2'b11, 2);
    run_op(32'hFFFF_FFFB, 32'd0, 2'b10, 2);
`else
    run_op(32'hFFFF_FFF9, 32'd2, 2'b10, 34);
    run_op(32'hFFFF_FFF9, 32'd2, 2'b11, 34);
`endif

    // Stall mid-CALC for 5 cycles; a start while busy must be ignored
    sb_q.push_back(model(32'd100, 32'd7, 2'b00));
    @(negedge clk);
    bus.dataa = 32'd100;
    bus.datab = 32'd7;
    bus.n     = 2'b00;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.dataa = 32'd200;
    bus.datab = 32'd10;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.clk_en = 1'b0;
    repeat (5) @(negedge clk);
    bus.clk_en = 1'b1;
    wait_done(t0, 39, "latency_stall");
    repeat (40) @(negedge clk);
    check("ignored_start_busy", {31'd0, bus.busy}, 32'd0);
    check("ignored_start_result", bus.result, 32'd14);

    // Completion lands while disabled: done withheld, then shown once
    sb_q.push_back(model(32'd90, 32'd9, 2'b00));
    @(negedge clk);
    bus.dataa = 32'd90;
    bus.datab = 32'd9;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    check("done_early", {31'd0, bus.done}, 32'd0);
    @(posedge clk);
    #1;
    bus.clk_en = 1'b0;
    #1;
    check("done_gated", {31'd0, bus.done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    bus.clk_en = 1'b1;
    #1;
    check("done_resume", {31'd0, bus.done}, 32'd1);
    @(posedge clk);
    #1;
    check("done_one_cycle", {31'd0, bus.done}, 32'd0);

    // Reset at edge 10 of an operation aborts it without a done pulse
    @(negedge clk);
    bus.dataa = 32'd100;
    bus.datab = 32'd7;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("abort_result", bus.result, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    run_op(32'd200, 32'd10, 2'b00, 34);

    // A few random operands
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 32'd0) rb = 32'd3;
      rn = 2'($urandom_range(0, 3));
      run_op(ra, rb, rn, 34);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
